// File: rtl/ss_seq_pkg.sv
// rtl/ss_seq_pkg.sv - shared constants, state encoding and CRC-8 helper for the save-state sequencer
package ss_seq_pkg;

   localparam int SS_WORDS_DFLT = 128;
   localparam int SETTLE_DFLT   = 2;
   localparam int M2_TO_DFLT    = 4096;
   localparam int SS_IDX_OFS    = SS_WORDS_DFLT - 1;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   typedef enum logic [3:0] {
      IDLE,
      REJECT,
      D_ADDR,
      D_SETTLE,
      D_PUSH,
      D_CRC,
      L_IDX,
      L_PULL,
      L_WR,
      L_EDGE,
      L_DRAIN,
      L_CRC,
      DONE
   } seq_state_e;

   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] d);
      logic [7:0] c;
      c = crc ^ d;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/ss_seq_if.sv
// rtl/ss_seq_if.sv - command/status, mapper save-state port and host byte streams of the sequencer
interface ss_seq_if;

   logic       cmd_save;
   logic       cmd_load;
   logic       busy;
   logic       done;
   logic       err;
   logic       ss_act;
   logic       ss_we;
   logic [7:0] ss_addr;
   logic [7:0] ss_wdat;
   logic [7:0] ss_rdat;
   logic [7:0] tx_dat;
   logic       tx_vld;
   logic       tx_rdy;
   logic [7:0] rx_dat;
   logic       rx_vld;
   logic       rx_rdy;

   modport master (
      input  cmd_save, cmd_load, ss_rdat, tx_rdy, rx_dat, rx_vld,
      output busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, tx_dat, tx_vld, rx_rdy
   );

   modport slave (
      output cmd_save, cmd_load, ss_rdat, tx_rdy, rx_dat, rx_vld,
      input  busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, tx_dat, tx_vld, rx_rdy
   );

endinterface

// File: rtl/m2_fall_sync.sv
// rtl/m2_fall_sync.sv - 2-flop synchronizer for async M2 plus one-clk falling-edge pulse m2f
module m2_fall_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic m2,
   output logic m2f
);

   logic [2:0] sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh <= '0;
      end else begin
         sh <= {sh[1:0], m2};
      end
   end

   // sh[1] is the synchronized level, sh[2] its previous value
   assign m2f = sh[2] & ~sh[1];

endmodule

// File: rtl/ss_seq_ctrl.sv
// rtl/ss_seq_ctrl.sv - save-state dump/restore sequencer; SS_SEQ_CRC_EN appends/checks a CRC-8 trailer byte
module ss_seq_ctrl
   import ss_seq_pkg::*;
#(
   parameter int SS_WORDS = SS_WORDS_DFLT,
   parameter int SETTLE   = SETTLE_DFLT,
   parameter int M2_TO    = M2_TO_DFLT
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     m2,
   ss_seq_if.master bus
);

   localparam logic [7:0]  IDX_ADDR    = 8'(SS_WORDS - 1);
   localparam logic [7:0]  LAST_ADDR   = 8'(SS_WORDS - 2);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
   localparam logic [15:0] SETTLE_CNT  = 16'(SETTLE);
   localparam logic [15:0] TO_CNT      = 16'(M2_TO);
`ifdef SS_SEQ_CRC_EN
   localparam logic [15:0] DRAIN_LEN   = 16'(SS_WORDS);
`else
   localparam logic [15:0] DRAIN_LEN   = 16'(SS_WORDS - 1);
`endif

   seq_state_e  state, state_nx;
   logic [7:0]  addr_q, addr_nx;
   logic [7:0]  wdat_q, wdat_nx;
   logic [7:0]  tdat_q, tdat_nx;
   logic [15:0] cnt_q, cnt_nx;
   logic        edge_q, edge_nx;
   logic        err_q, err_nx;
`ifdef SS_SEQ_CRC_EN
   logic [7:0]  crc_q, crc_nx;
`endif
   logic        busy, done, ss_act, ss_we, tx_vld, rx_rdy;
   logic        m2f;

   m2_fall_sync u_m2_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .m2    (m2),
      .m2f   (m2f)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         addr_q <= '0;
         wdat_q <= '0;
         tdat_q <= '0;
         cnt_q  <= '0;
         edge_q <= 1'b0;
         err_q  <= 1'b0;
`ifdef SS_SEQ_CRC_EN
         crc_q  <= CRC8_INIT;
`endif
      end else begin
         state  <= state_nx;
         addr_q <= addr_nx;
         wdat_q <= wdat_nx;
         tdat_q <= tdat_nx;
         cnt_q  <= cnt_nx;
         edge_q <= edge_nx;
         err_q  <= err_nx;
`ifdef SS_SEQ_CRC_EN
         crc_q  <= crc_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state;
      addr_nx  = addr_q;
      wdat_nx  = wdat_q;
      tdat_nx  = tdat_q;
      cnt_nx   = cnt_q;
      edge_nx  = edge_q;
      err_nx   = err_q;
`ifdef SS_SEQ_CRC_EN
      crc_nx   = crc_q;
`endif
      busy     = 1'b1;
      ss_act   = 1'b1;
      done     = 1'b0;
      ss_we    = 1'b0;
      tx_vld   = 1'b0;
      rx_rdy   = 1'b0;

      unique case (state)
         IDLE: begin
            busy   = 1'b0;
            ss_act = 1'b0;
            if (bus.cmd_save && bus.cmd_load) begin
               err_nx   = 1'b1;
               state_nx = REJECT;
            end else if (bus.cmd_save || bus.cmd_load) begin
               err_nx   = 1'b0;
               addr_nx  = IDX_ADDR;
               cnt_nx   = '0;
`ifdef SS_SEQ_CRC_EN
               crc_nx   = CRC8_INIT;
`endif
               state_nx = bus.cmd_save ? D_SETTLE : L_IDX;
            end
         end

         REJECT: begin
            busy     = 1'b0;
            ss_act   = 1'b0;
            done     = 1'b1;
            state_nx = IDLE;
         end

         // map_idx leads the stream, so the address after it wraps to 0
         D_ADDR: begin
            addr_nx  = (addr_q == IDX_ADDR) ? 8'd0 : addr_q + 8'd1;
            cnt_nx   = '0;
            state_nx = D_SETTLE;
         end

         D_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               tdat_nx  = bus.ss_rdat;
               state_nx = D_PUSH;
            end else begin
               cnt_nx = cnt_q + 16'd1;
            end
         end

         D_PUSH: begin
            tx_vld = 1'b1;
            if (bus.tx_rdy) begin
`ifdef SS_SEQ_CRC_EN
               crc_nx = crc8_upd(crc_q, tdat_q);
`endif
               if (addr_q == LAST_ADDR) begin
`ifdef SS_SEQ_CRC_EN
                  tdat_nx  = crc8_upd(crc_q, tdat_q);
                  state_nx = D_CRC;
`else
                  state_nx = DONE;
`endif
               end else begin
                  state_nx = D_ADDR;
               end
            end
         end

`ifdef SS_SEQ_CRC_EN
         D_CRC: begin
            tx_vld = 1'b1;
            if (bus.tx_rdy) begin
               state_nx = DONE;
            end
         end
`endif

         L_IDX: begin
            if (cnt_q != SETTLE_CNT) begin
               cnt_nx = cnt_q + 16'd1;
            end else begin
               rx_rdy = 1'b1;
               if (bus.rx_vld) begin
`ifdef SS_SEQ_CRC_EN
                  crc_nx = crc8_upd(crc_q, bus.rx_dat);
`endif
                  if (bus.rx_dat != bus.ss_rdat) begin
                     err_nx   = 1'b1;
                     cnt_nx   = DRAIN_LEN;
                     state_nx = L_DRAIN;
                  end else begin
                     addr_nx  = 8'd0;
                     state_nx = L_PULL;
                  end
               end
            end
         end

         L_PULL: begin
            rx_rdy = 1'b1;
            if (bus.rx_vld) begin
               wdat_nx  = bus.rx_dat;
`ifdef SS_SEQ_CRC_EN
               crc_nx   = crc8_upd(crc_q, bus.rx_dat);
`endif
               state_nx = L_WR;
            end
         end

         L_WR: begin
            ss_we    = 1'b1;
            edge_nx  = m2f;
            cnt_nx   = '0;
            state_nx = L_EDGE;
         end

         // the first counted edge may predate the strobe at the mapper, so hold for a second one
         L_EDGE: begin
            ss_we = 1'b1;
            if (m2f) begin
               cnt_nx = '0;
               if (edge_q) begin
                  if (addr_q == LAST_ADDR) begin
`ifdef SS_SEQ_CRC_EN
                     state_nx = L_CRC;
`else
                     state_nx = DONE;
`endif
                  end else begin
                     addr_nx  = addr_q + 8'd1;
                     state_nx = L_PULL;
                  end
               end else begin
                  edge_nx = 1'b1;
               end
            end else if (cnt_q == TO_CNT) begin
               err_nx   = 1'b1;
               state_nx = DONE;
            end else begin
               cnt_nx = cnt_q + 16'd1;
            end
         end

         L_DRAIN: begin
            rx_rdy = 1'b1;
            if (bus.rx_vld) begin
               if (cnt_q == 16'd1) begin
                  state_nx = DONE;
               end else begin
                  cnt_nx = cnt_q - 16'd1;
               end
            end
         end

`ifdef SS_SEQ_CRC_EN
         L_CRC: begin
            rx_rdy = 1'b1;
            if (bus.rx_vld) begin
               if (bus.rx_dat != crc_q) begin
                  err_nx = 1'b1;
               end
               state_nx = DONE;
            end
         end
`endif

         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.err     = err_q;
   assign bus.ss_act  = ss_act;
   assign bus.ss_we   = ss_we;
   assign bus.ss_addr = addr_q;
   assign bus.ss_wdat = wdat_q;
   assign bus.tx_dat  = tdat_q;
   assign bus.tx_vld  = tx_vld;
   assign bus.rx_rdy  = rx_rdy;

endmodule

// File: tb/tb_ss_seq_ctrl.sv
// tb/tb_ss_seq_ctrl.sv - directed self-checking bench for ss_seq_ctrl with a behavioural mapper model
module tb_ss_seq_ctrl;
   import ss_seq_pkg::*;

`ifdef SS_SEQ_CRC_EN
   localparam int N_STREAM = SS_WORDS_DFLT + 1;
`else
   localparam int N_STREAM = SS_WORDS_DFLT;
`endif

   logic clk;
   logic rst_n;
   logic m2;
   logic m2_run;

   ss_seq_if bus ();

   ss_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m2    (m2),
      .bus   (bus)
   );

   int vecs = 0;
   int miscmp = 0;

   logic [7:0] mem [128];
   logic [7:0] got [$];
   logic [7:0] feed [$];
   int         done_n;
   int         consumed;
   int         we_cycles;
   logic       err_at_done;
   logic       we_at_done;
   logic       hold_bad;
   logic       act_seen;
   logic       both_seen = 1'b0;

   logic [2:0] bsh;
   logic       bm2f;
   int         we_m2f = 0;
   int         min_m2f = 999;
   int         nwr = 0;
   logic       we_prev = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // roughly 1.79 MHz M2, or held low when m2_run is cleared
   initial begin
      m2 = 1'b1;
      forever begin
         if (m2_run) begin
            #280 m2 = ~m2;
         end else begin
            m2 = 1'b0;
            #10;
         end
      end
   end

   assign bus.ss_rdat = mem[bus.ss_addr[6:0]];

   always @(negedge m2) begin
      if (bus.ss_act && bus.ss_we && bus.ss_addr < 8'd127) mem[bus.ss_addr[6:0]] = bus.ss_wdat;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bsh <= 3'b000;
      else        bsh <= {bsh[1:0], m2};
   end
   assign bm2f = bsh[2] & ~bsh[1];

   always @(posedge clk) begin
      if (we_prev && !bus.ss_we) begin
         nwr = nwr + 1;
         if (we_m2f < min_m2f) min_m2f = we_m2f;
         we_m2f = 0;
      end
      if (bus.ss_we && bm2f) we_m2f = we_m2f + 1;
      we_prev = bus.ss_we;
   end

   always @(negedge clk) begin
      if (bus.tx_vld && bus.rx_rdy) both_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [30:0] outs();
      return {bus.busy, bus.done, bus.err, bus.ss_act, bus.ss_we, bus.tx_vld, bus.rx_rdy,
              bus.ss_addr, bus.ss_wdat, bus.tx_dat};
   endfunction

   function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] d);
      logic [7:0] c;
      logic       fb;
      c = c_in;
      for (int b = 7; b >= 0; b--) begin
         fb = c[7] ^ d[b];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   function automatic logic [7:0] exp_dump(input int i);
      return (i == 0) ? mem[SS_IDX_OFS] : mem[i - 1];
   endfunction

   task automatic run_dump(input int mode);
      logic       held_v;
      logic [7:0] held_d;
      got.delete();
      done_n = 0;
      hold_bad = 1'b0;
      held_v = 1'b0;
      held_d = 8'h00;
      @(negedge clk) bus.cmd_save = 1'b1;
      @(negedge clk) bus.cmd_save = 1'b0;
      for (int cyc = 0; cyc < 3000 && done_n == 0; cyc++) begin
         bus.tx_rdy = (mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 1);
         if (held_v && bus.tx_vld && bus.tx_dat !== held_d) hold_bad = 1'b1;
         held_v = bus.tx_vld && !bus.tx_rdy;
         held_d = bus.tx_dat;
         if (bus.tx_vld && bus.tx_rdy) got.push_back(bus.tx_dat);
         if (bus.done) begin
            done_n++;
            err_at_done = bus.err;
         end
         @(negedge clk);
      end
      bus.tx_rdy = 1'b0;
   endtask

   task automatic check_dump(input string tag);
      int         bad;
      logic [7:0] c;
      bad = 0;
      c = 8'h00;
      for (int i = 0; i < SS_WORDS_DFLT; i++) begin
         if (i >= got.size() || got[i] !== exp_dump(i)) bad++;
         c = ref_crc(c, exp_dump(i));
      end
`ifdef SS_SEQ_CRC_EN
      if (got.size() <= SS_WORDS_DFLT || got[SS_WORDS_DFLT] !== c) bad++;
`endif
      chk({tag, "_len"}, got.size(), N_STREAM);
      chk({tag, "_bad_bytes"}, bad, 0);
      chk({tag, "_done"}, done_n, 1);
      chk({tag, "_err"}, err_at_done, 1'b0);
      chk({tag, "_busy_drop"}, {bus.busy, bus.ss_act}, 2'b00);
   endtask

   task automatic run_load();
      consumed = 0;
      done_n = 0;
      we_cycles = 0;
      err_at_done = 1'b0;
      we_at_done = 1'b1;
      @(negedge clk) bus.cmd_load = 1'b1;
      @(negedge clk) bus.cmd_load = 1'b0;
      for (int cyc = 0; cyc < 30000 && done_n == 0; cyc++) begin
         if (consumed < feed.size()) begin
            bus.rx_vld = 1'b1;
            bus.rx_dat = feed[consumed];
         end else begin
            bus.rx_vld = 1'b0;
         end
         if (bus.rx_rdy && bus.rx_vld) consumed++;
         if (bus.ss_we) we_cycles++;
         if (bus.done) begin
            done_n++;
            err_at_done = bus.err;
            we_at_done = bus.ss_we;
         end
         @(negedge clk);
      end
      bus.rx_vld = 1'b0;
   endtask

   initial begin
      int         bad;
      logic [7:0] c;
      m2_run = 1'b1;
      rst_n = 1'b0;
      bus.cmd_save = 1'b0;
      bus.cmd_load = 1'b0;
      bus.tx_rdy = 1'b0;
      bus.rx_dat = 8'h00;
      bus.rx_vld = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 8'hFF;
      mem[0] = 8'h5A;
      mem[SS_IDX_OFS] = 8'd70;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs(), 31'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_dump(0);
      check_dump("dump_rdy1");
      chk("dump_first_idx", got[0], 8'h46);
      chk("dump_second", got[1], 8'h5A);

      run_dump(1);
      check_dump("dump_toggle");
      chk("dump_hold", hold_bad, 1'b0);

      // restore: idx 70, addr0 0x3C, then addr n gets n*3+1
      feed.delete();
      feed.push_back(8'd70);
      feed.push_back(8'h3C);
      for (int a = 1; a <= 126; a++) feed.push_back(8'(a * 3 + 1));
`ifdef SS_SEQ_CRC_EN
      c = 8'h00;
      foreach (feed[i]) c = ref_crc(c, feed[i]);
      feed.push_back(c);
`endif
      nwr = 0;
      min_m2f = 999;
      run_load();
      chk("load_done", done_n, 1);
      chk("load_err", err_at_done, 1'b0);
      chk("load_consumed", consumed, N_STREAM);
      chk("load_mem0", mem[0], 8'h3C);
      chk("load_mem126", mem[126], 8'h7B);
      chk("load_idx_ro", mem[127], 8'h46);
      bad = 0;
      for (int a = 1; a <= 126; a++) if (mem[a] !== 8'(a * 3 + 1)) bad++;
      chk("load_mem_bad", bad, 0);
      chk("load_writes", nwr, 127);
      chk("load_we_2edges", (min_m2f >= 2), 1'b1);
      chk("load_busy_drop", bus.busy, 1'b0);

      feed.delete();
      feed.push_back(8'd152);
      for (int i = 1; i < N_STREAM; i++) feed.push_back(8'h11);
      run_load();
      chk("idxbad_done", done_n, 1);
      chk("idxbad_err", err_at_done, 1'b1);
      chk("idxbad_consumed", consumed, N_STREAM);
      chk("idxbad_no_we", we_cycles, 0);
      chk("idxbad_mem0", mem[0], 8'h3C);

      m2_run = 1'b0;
      repeat (10) @(negedge clk);
      feed.delete();
      feed.push_back(8'd70);
      feed.push_back(8'h99);
      feed.push_back(8'h98);
      feed.push_back(8'h97);
      run_load();
      chk("tmo_done", done_n, 1);
      chk("tmo_err", err_at_done, 1'b1);
      chk("tmo_we_at_done", we_at_done, 1'b0);
      chk("tmo_consumed", consumed, 2);
      chk("tmo_len", (we_cycles > M2_TO_DFLT && we_cycles <= M2_TO_DFLT + 4), 1'b1);
      chk("tmo_busy_drop", {bus.busy, bus.ss_we}, 2'b00);
      chk("tmo_mem0", mem[0], 8'h3C);
      m2_run = 1'b1;

      bus.tx_rdy = 1'b0;
      @(negedge clk) bus.cmd_save = 1'b1;
      @(negedge clk) bus.cmd_save = 1'b0;
      repeat (8) @(negedge clk);
      chk("middump_active", {bus.busy, bus.ss_act, bus.tx_vld}, 3'b111);
      #2 rst_n = 1'b0;
      #1 chk("middump_reset_outs", outs(), 31'h0);
      @(negedge clk) rst_n = 1'b1;
      done_n = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) done_n++;
      end
      chk("middump_no_done", done_n, 0);

`ifdef SS_SEQ_CRC_EN
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      run_dump(0);
      chk("crc_zero_len", got.size(), N_STREAM);
      chk("crc_zero_byte", got[SS_WORDS_DFLT], 8'h00);
      mem[SS_IDX_OFS] = 8'd70;
`endif

      @(negedge clk);
      bus.cmd_save = 1'b1;
      bus.cmd_load = 1'b1;
      @(negedge clk);
      bus.cmd_save = 1'b0;
      bus.cmd_load = 1'b0;
      done_n = 0;
      act_seen = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (bus.done) done_n++;
         if (bus.ss_act || bus.busy) act_seen = 1'b1;
         @(negedge clk);
      end
      chk("dual_done", done_n, 1);
      chk("dual_no_act", act_seen, 1'b0);
      chk("dual_err", bus.err, 1'b1);

      chk("never_rdy_and_vld", both_seen, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule

// File: doc/ss_seq_ctrl.md
Name: ss_seq_ctrl

Overview:
- Save-state sequencer for the mapper save-state port (ss_act/ss_we/ss_addr/ss_rdat/cpu_dat).
- Walks the mapper's save-state address space and streams register bytes to the host (dump), or from the host into the mapper (restore).
- Sits between the host byte-stream link and every mapper module.
- Holds the mapper frozen (ss_act) while a transfer runs.
- Times writes against the asynchronous M2 falling edge, because mappers latch save-state writes on negedge m2.

Parameters:
- SS_WORDS, 128: number of save-state addresses, 0..SS_WORDS-1. Address SS_WORDS-1 is the read-only mapper index (map_idx).
- SETTLE, 2: clk cycles between an ss_addr change and sampling ss_rdat.
- M2_TO, 4096: clk cycles to wait for an M2 falling edge before declaring a timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m2  in  1  CPU M2, asynchronous to clk
- cmd_save  in  1  one-cycle pulse: start dump
- cmd_load  in  1  one-cycle pulse: start restore
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end, on success or error
- err  out  1  sticky error flag; cleared by the next accepted command
- ss_act  out  1  mapper save-state mode
- ss_we  out  1  save-state write strobe
- ss_addr  out  8  save-state address
- ss_wdat  out  8  write data, driven onto cpu_dat while ss_act is high
- ss_rdat  in  8  mapper readback
- tx_dat  out  8, tx_vld  out  1, tx_rdy  in  1  dump stream to host
- rx_dat  in  8, rx_vld  in  1, rx_rdy  out  1  restore stream from host

Behaviour:
- Reset: all outputs 0; state IDLE.
- Reset applies asynchronously mid-transfer. ss_act and ss_we drop immediately and no done pulse is generated.
- m2 passes through a 2-flop synchronizer, then a falling-edge detector producing a one-clk pulse m2f.
- Commands are accepted only in IDLE. If cmd_save and cmd_load arrive in the same cycle, both are rejected: err=1, done pulses, no transfer. Commands arriving while busy are ignored.
- Accepting a command: clears err, sets busy=1 and ss_act=1.
- busy and ss_act stay high until the cycle after done.
- Stream order, both directions: byte 0 = address SS_WORDS-1 (map_idx), then addresses 0..SS_WORDS-2. Total SS_WORDS bytes.
- Dump states: D_ADDR → D_SETTLE → D_PUSH.
  - D_ADDR: load ss_addr.
  - D_SETTLE: count SETTLE cycles.
  - D_PUSH: present tx_dat=ss_rdat with tx_vld=1. Hold tx_dat stable until tx_rdy, then advance.
  - After the last byte: DONE.
- Load states: L_IDX → L_PULL → L_WR → L_EDGE.
  - L_IDX: ss_addr=SS_WORDS-1. After SETTLE cycles, accept a byte (rx_rdy=1). If the byte ≠ ss_rdat: err=1, enter L_DRAIN.
  - L_PULL: rx_rdy=1 for one handshake; latch ss_wdat.
  - L_WR: ss_we=1, with ss_addr and ss_wdat stable.
  - L_EDGE: wait for the second m2f after ss_we rose, then drop ss_we. The first edge may predate the strobe at the mapper, so a second edge is required; a duplicate write is idempotent.
  - Advance the address and return to L_PULL. After address SS_WORDS-2: DONE.
- L_DRAIN: rx_rdy=1. Consume the remaining SS_WORDS-1 bytes with no writes, then DONE.
- Timeout: in L_EDGE, more than M2_TO clk cycles without m2f → drop ss_we, err=1, DONE. The remaining rx bytes are not consumed.
- rx_rdy and tx_vld are never both high. ss_we is high only in L_WR and L_EDGE.
- Address counter: 8-bit, no wrap. Termination is by compare against SS_WORDS-2.

Optional Feature:
- Macro SS_SEQ_CRC_EN.
- Defined:
  - Dump appends one CRC-8 byte (poly 0x07, init 0x00) over all SS_WORDS bytes; the stream becomes SS_WORDS+1 bytes.
  - Load expects the same trailing byte after the last write, computed over received bytes. Mismatch sets err; writes are not undone.
- Undefined: no CRC logic; streams are exactly SS_WORDS bytes.

Decomposition:
- Package ss_seq_pkg: state encoding, SS_IDX_OFS (=SS_WORDS-1), CRC8_POLY, CRC8_INIT.
- Sub-module m2_fall_sync: 2-flop synchronizer plus falling-edge pulse. Reusable by other clk-domain mapper logic.

Test Plan:
- Dump, mapper model returning {prg,chr}=0x5A at addr 0, idx=70 at 127, 0xFF elsewhere; tx_rdy always 1 → stream 70, 0x5A, then 126×0xFF. done after the last handshake; err=0.
- Dump with tx_rdy toggling every 3 cycles → identical byte sequence; tx_dat stable while tx_vld && !tx_rdy.
- Load, idx byte 70 matching, addr-0 byte 0x3C, M2 at 1.79 MHz → model register=0x3C. ss_we spans ≥2 M2 falling edges. done pulses with err=0.
- Load with idx byte 152 vs mapper 70 → no ss_we ever; all 128 bytes consumed; err=1; done pulses.
- Load with m2 held low → timeout after M2_TO cycles; err=1; ss_we=0; busy drops. Then rst_n asserted mid-dump → all outputs 0 immediately.
- cmd_save and cmd_load in the same cycle → err=1, done pulse, ss_act never asserted. With SS_SEQ_CRC_EN, dump of all-0x00 data gives CRC byte 0x00.
